// File: rtl/demux8_dispatch_pkg.sv
// Shared types and constants for the 1-to-8 dispatch controller.
package demux8_dispatch_pkg;
  localparam int NUM_OUT = 8;
  localparam int SEL_W   = 3;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/demux8_dispatch_ctrl_rr_pick8.sv
// Rotating-priority search: first asserted req at or after ptr (mod 8).
// With no request asserted, idx falls back to ptr and found stays low.
module rr_pick8
  import demux8_dispatch_pkg::*;
(
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_OUT-1:0] req,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    // Walk from the farthest offset down so the nearest hit is assigned last.
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx   = ptr + SEL_W'(k);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux8_dispatch_ctrl.sv
// One-entry dispatch controller for a 1-to-8 demux, addressed or round-robin.
// Optional stall timeout with a drop pulse: define DEMUX8_DISPATCH_TIMEOUT_EN.
module demux8_dispatch_ctrl
  import demux8_dispatch_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [SEL_W-1:0]   in_dest,
  input  logic               mode,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DW-1:0]      out_data,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [15:0]        sent_cnt
`ifdef DEMUX8_DISPATCH_TIMEOUT_EN
  ,
  output logic               drop
`endif
);
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  state_t             r_state, w_next;
  logic [DW-1:0]      r_data;
  logic [SEL_W-1:0]   r_sel, r_rr_ptr, w_idx, w_target;
  logic [15:0]        r_sent_cnt;
  logic               w_found, w_accept, w_done, w_tmo;

  rr_pick8 u_pick (
    .ptr   (r_rr_ptr),
    .req   (out_ready),
    .idx   (w_idx),
    .found (w_found)
  );

  assign w_target = (mode == MODE_RR) ? (w_found ? w_idx : r_rr_ptr) : in_dest;
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_done   = (r_state == HOLD) && out_ready[r_sel];

`ifdef DEMUX8_DISPATCH_TIMEOUT_EN
  logic [7:0] r_stall;
  logic       r_drop;

  // Fires on the stall cycle that brings the count up to TIMEOUT.
  assign w_tmo = (r_state == HOLD) && !out_ready[r_sel] &&
                 (r_stall + 8'd1 == 8'(TIMEOUT));
  assign drop  = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= 8'd0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_tmo;
      if (w_accept)
        r_stall <= 8'd0;
      else if (r_state == HOLD && !out_ready[r_sel])
        r_stall <= r_stall + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = HOLD;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = NUM_OUT'(1) << r_sel;
        if (w_done || w_tmo) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_sel      <= '0;
      r_sent_cnt <= 16'd0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_sel  <= w_target;
      end
      if (w_done)
        r_sent_cnt <= r_sent_cnt + 16'd1;
      // Both completion and drop move the round-robin pointer past sel.
      if (w_done || w_tmo)
        r_rr_ptr <= r_sel + SEL_W'(1);
    end
  end

  assign out_data = r_data;
  assign sel      = r_sel;
  assign sent_cnt = r_sent_cnt;
endmodule

// File: doc/demux8_dispatch_ctrl.md
Name: demux8_dispatch_ctrl

Overview:
- Sequencing controller for a 1-to-8 demultiplexed datapath.
- Accepts words on a single valid/ready input and holds each one in a one-entry register.
- Drives the 3-bit select plus a one-hot out_valid toward eight consumers and completes a valid/ready handshake with the selected consumer.
- Two routing modes: addressed (destination comes with the word) and round-robin (controller picks the destination, skipping consumers that are not ready).

Parameters:
- DW, 8, data word width.
- TIMEOUT, 15, stall cycles before a held word is dropped (used only when the optional feature is compiled in); legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  controller can accept a word.
- in_data  input  DW  upstream word.
- in_dest  input  3  destination index; used in addressed mode only.
- mode  input  1  0 = addressed, 1 = round-robin; sampled only on the accept cycle.
- out_ready  input  8  per-consumer ready.
- out_valid  output  8  one-hot valid for the selected consumer, else 0.
- out_data  output  DW  held word, broadcast to all consumers.
- sel  output  3  current demux select.
- busy  output  1  a word is held.
- sent_cnt  output  16  count of completed output transfers.

Behaviour:
- Reset (asserted asynchronously) forces:
  - state = IDLE; in_ready = 1; out_valid = 0; out_data = 0; sel = 0; busy = 0; sent_cnt = 0; rr_ptr = 0.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - in_ready = 1, busy = 0, out_valid = 0.
  - If in_valid = 1: latch in_data into out_data, latch the target into sel, go to HOLD.
- Target selection on the accept cycle:
  - Addressed mode: target = in_dest.
  - Round-robin mode: target = first index i in rr_ptr, rr_ptr+1, ... (mod 8) with out_ready[i] = 1.
  - Round-robin with no consumer ready: target = rr_ptr.
- HOLD:
  - in_ready = 0, busy = 1, out_valid = one-hot of sel.
  - sel and out_data stay stable until the transfer completes.
  - Transfer completes when out_ready[sel] = 1. On that cycle:
    - go to IDLE;
    - sent_cnt increments;
    - rr_ptr = sel + 1 (mod 8; 7 wraps to 0). rr_ptr updates in both modes.
- Latency:
  - out_valid asserts on the cycle after acceptance.
  - Peak throughput is one word per 2 cycles; no accept in the same cycle as a completion.
- out_ready bits other than sel are ignored while in HOLD.
- A change on mode while in HOLD has no effect.
- sent_cnt wraps from 0xFFFF to 0x0000.
- Reset asserted mid-HOLD discards the held word; no transfer is counted.

Optional Feature:
- Macro: DEMUX8_DISPATCH_TIMEOUT_EN.
- When defined:
  - Adds an 8-bit stall counter, cleared on entry to HOLD.
  - Increments each HOLD cycle in which out_ready[sel] = 0.
  - When the counter reaches TIMEOUT: return to IDLE and pulse the extra output port drop (1 bit) for one cycle.
  - The dropped word does not increment sent_cnt, and rr_ptr advances past sel.
  - drop resets to 0.
- When undefined:
  - No counter and no drop port.
  - HOLD waits indefinitely.

Decomposition:
- Package demux8_dispatch_pkg holds:
  - the state typedef (IDLE, HOLD);
  - constants NUM_OUT = 8 and SEL_W = 3;
  - mode constants MODE_ADDR = 0 and MODE_RR = 1.
- One sub-module, rr_pick8: purely combinational rotating-priority search.
  - Inputs: ptr[3], req[8].
  - Outputs: idx[3], found.

Test Plan:
- Reset sequence: assert rst mid-HOLD -> out_valid = 0, busy = 0, in_ready = 1 immediately (asynchronous); sent_cnt = 0 and sel = 0 after release.
- Addressed mode: mode = 0, in_dest = 5, in_data = 0xA5, out_ready = 0xFF -> cycle +1 sel = 5, out_valid = 0x20, out_data = 0xA5; cycle +2 IDLE, sent_cnt = 1.
- Backpressure: addressed word to dest 2, out_ready = 0x00 for 4 cycles, then 0x04 -> out_valid = 0x04 held 5 cycles, data stable, one transfer counted.
- Round-robin skip: mode = 1, rr_ptr = 6, out_ready = 0x09 -> sel = 0; after the transfer rr_ptr = 1; next word with out_ready = 0x09 -> sel = 3.
- Round-robin with none ready: rr_ptr = 7, out_ready = 0x00 at accept -> sel = 7, waits; out_ready[7] = 1 completes the transfer; rr_ptr wraps to 0.
- Counter wrap and timeout: preload sent_cnt = 0xFFFF via 65535 transfers (or force), one more transfer -> sent_cnt = 0x0000. With DEMUX8_DISPATCH_TIMEOUT_EN and TIMEOUT = 3, a stall on dest 4 -> drop pulses 3 cycles after HOLD entry, sent_cnt unchanged.
